// File: rtl/fp_align_stage.sv
// Purpose : single-precision add pre-stage: magnitude order, hidden-bit restore, GRS alignment, special resolve.
// Latency : 2 cycles from accept to out_valid (S1 compare/classify, S2 align/special), 1 pair/cycle.
// Backpr. : valid/ready; outputs held while out_valid & !out_ready; optional FTZ via `FP_ALIGN_FTZ_EN.
module fp_align_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MANT_W:0] in_a,
    input  logic [EXP_W+MANT_W:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign_big,
    output logic                  out_eff_sub,
    output logic [EXP_W-1:0]      out_exp,
    output logic [MANT_W+3:0]     out_mant_big,
    output logic [MANT_W+3:0]     out_mant_small,
    output logic                  out_special,
    output logic [EXP_W+MANT_W:0] out_special_res
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int XM = MANT_W + 4;
    localparam int MW = MANT_W + 1;

    localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s1_rdy, s2_rdy;

    assign s2_rdy   = !s2_v_q || out_ready;
    assign s1_rdy   = !s1_v_q || s2_rdy;
    assign in_ready = !rst && s1_rdy;

    // Valid bits advance whenever the stage ahead of them has room.
    always_comb begin
        s1_v_d = s1_rdy ? in_valid : s1_v_q;
        s2_v_d = s2_rdy ? s1_v_q   : s2_v_q;
    end

    // Valid bit registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: compare / classify
    // ------------------------------------------------------------------
    logic [W-1:0] a_f, b_f;

    // Operands as seen by the datapath (subnormals optionally flushed to signed zero).
    always_comb begin
        a_f = in_a;
        b_f = in_b;
`ifdef FP_ALIGN_FTZ_EN
        if (in_a[W-2:MANT_W] == '0) a_f = {in_a[W-1], {(W-1){1'b0}}};
        if (in_b[W-2:MANT_W] == '0) b_f = {in_b[W-1], {(W-1){1'b0}}};
`endif
    end

    logic             a_ge_b;
    logic [W-2:0]     big_mag, small_mag;
    logic [EXP_W-1:0] exp_big_raw, exp_small_raw, exp_big_eff, exp_small_eff;
    logic             hid_big, hid_small;
    logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    // Ties pick A so the larger-operand sign is deterministic.
    assign a_ge_b        = a_f[W-2:0] >= b_f[W-2:0];
    assign big_mag       = a_ge_b ? a_f[W-2:0] : b_f[W-2:0];
    assign small_mag     = a_ge_b ? b_f[W-2:0] : a_f[W-2:0];
    assign exp_big_raw   = big_mag[W-2:MANT_W];
    assign exp_small_raw = small_mag[W-2:MANT_W];
    assign hid_big       = |exp_big_raw;
    assign hid_small     = |exp_small_raw;
    assign exp_big_eff   = hid_big   ? exp_big_raw   : EXP_W'(1);
    assign exp_small_eff = hid_small ? exp_small_raw : EXP_W'(1);

    assign a_nan  = (&a_f[W-2:MANT_W]) && (|a_f[MANT_W-1:0]);
    assign a_inf  = (&a_f[W-2:MANT_W]) && !(|a_f[MANT_W-1:0]);
    assign a_zero = !(|a_f[W-2:0]);
    assign b_nan  = (&b_f[W-2:MANT_W]) && (|b_f[MANT_W-1:0]);
    assign b_inf  = (&b_f[W-2:MANT_W]) && !(|b_f[MANT_W-1:0]);
    assign b_zero = !(|b_f[W-2:0]);

    logic             s1_sign_big_q, s1_eff_sub_q, s1_sa_q, s1_sb_q;
    logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
    logic [MW-1:0]    s1_mant_big_q, s1_mant_small_q;
    logic             s1_a_nan_q, s1_a_inf_q, s1_a_zero_q;
    logic             s1_b_nan_q, s1_b_inf_q, s1_b_zero_q;

    // S1 payload captures on every accepted pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_big_q   <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_sa_q         <= 1'b0;
            s1_sb_q         <= 1'b0;
            s1_exp_q        <= '0;
            s1_diff_q       <= '0;
            s1_mant_big_q   <= '0;
            s1_mant_small_q <= '0;
            s1_a_nan_q      <= 1'b0;
            s1_a_inf_q      <= 1'b0;
            s1_a_zero_q     <= 1'b0;
            s1_b_nan_q      <= 1'b0;
            s1_b_inf_q      <= 1'b0;
            s1_b_zero_q     <= 1'b0;
        end else if (in_valid && s1_rdy) begin
            s1_sign_big_q   <= a_ge_b ? a_f[W-1] : b_f[W-1];
            s1_eff_sub_q    <= a_f[W-1] ^ b_f[W-1];
            s1_sa_q         <= a_f[W-1];
            s1_sb_q         <= b_f[W-1];
            s1_exp_q        <= exp_big_eff;
            s1_diff_q       <= exp_big_eff - exp_small_eff;
            s1_mant_big_q   <= {hid_big, big_mag[MANT_W-1:0]};
            s1_mant_small_q <= {hid_small, small_mag[MANT_W-1:0]};
            s1_a_nan_q      <= a_nan;
            s1_a_inf_q      <= a_inf;
            s1_a_zero_q     <= a_zero;
            s1_b_nan_q      <= b_nan;
            s1_b_inf_q      <= b_inf;
            s1_b_zero_q     <= b_zero;
        end
    end

    // ------------------------------------------------------------------
    // S2: align / special
    // ------------------------------------------------------------------
    logic [XM-1:0] small_ext, small_shr, small_lost, small_al;

    // Bits pushed past bit 0 collapse into sticky; shifts >= XM leave only sticky.
    assign small_ext  = {s1_mant_small_q, 3'b000};
    assign small_shr  = small_ext >> s1_diff_q;
    assign small_lost = small_ext & ~({XM{1'b1}} << s1_diff_q);
    assign small_al   = small_shr | {{(XM-1){1'b0}}, |small_lost};

    logic         spec_d;
    logic [W-1:0] spec_res_d;

    // Special-operand resolution in priority order: NaN / inf-inf, inf, both zero.
    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = QNAN;
        if (s1_a_nan_q || s1_b_nan_q || (s1_a_inf_q && s1_b_inf_q && (s1_sa_q != s1_sb_q))) begin
            spec_res_d = QNAN;
        end else if (s1_a_inf_q) begin
            spec_res_d = {s1_sa_q, INF_MAG};
        end else if (s1_b_inf_q) begin
            spec_res_d = {s1_sb_q, INF_MAG};
        end else if (s1_a_zero_q && s1_b_zero_q) begin
            spec_res_d = {s1_sa_q && s1_sb_q, {(W-1){1'b0}}};
        end else begin
            spec_d     = 1'b0;
            spec_res_d = '0;
        end
    end

    logic             sign_big_q, eff_sub_q, special_q;
    logic [EXP_W-1:0] exp_q;
    logic [XM-1:0]    mant_big_q, mant_small_q;
    logic [W-1:0]     special_res_q;

    // Output registers only move when S2 is free or being popped, which gives the hold rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_big_q    <= 1'b0;
            eff_sub_q     <= 1'b0;
            exp_q         <= '0;
            mant_big_q    <= '0;
            mant_small_q  <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else if (s2_rdy && s1_v_q) begin
            sign_big_q    <= s1_sign_big_q;
            eff_sub_q     <= s1_eff_sub_q;
            exp_q         <= s1_exp_q;
            mant_big_q    <= {s1_mant_big_q, 3'b000};
            mant_small_q  <= small_al;
            special_q     <= spec_d;
            special_res_q <= spec_res_d;
        end
    end

    assign out_valid       = s2_v_q;
    assign out_sign_big    = sign_big_q;
    assign out_eff_sub     = eff_sub_q;
    assign out_exp         = exp_q;
    assign out_mant_big    = mant_big_q;
    assign out_mant_small  = mant_small_q;
    assign out_special     = special_q;
    assign out_special_res = special_res_q;

endmodule
